// File: rtl/exu_brchslv_reg.sv
// Branch-resolve unit on the EXU commit path: detects mispredicts, raises a
// registered flush with the redirect PC, pulses predictor updates and counts events.
module exu_brchslv_reg #(
  parameter int unsigned PC_SIZE     = 32,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmt_i_valid,
  output logic               cmt_i_ready,
  input  logic               cmt_i_bjp,
  input  logic               cmt_i_jalr,
  input  logic               cmt_i_bjp_prdt,
  input  logic               cmt_i_bjp_rslv,
  input  logic [PC_SIZE-1:0] cmt_i_pc,
  input  logic [XLEN-1:0]    cmt_i_imm,
  input  logic [XLEN-1:0]    cmt_i_rs1,
  output logic               brchmis_flush_req,
  input  logic               brchmis_flush_ack,
  output logic [PC_SIZE-1:0] brchmis_flush_pc,
  output logic               bpu_upd_valid,
  output logic [PC_SIZE-1:0] bpu_upd_pc,
  output logic               bpu_upd_taken,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   cnt_bjp,
  output logic [CNT_W-1:0]   cnt_mis,
  output logic               dbg_state_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [PC_SIZE-1:0] FALL_INC = PC_SIZE'(INSTR_BYTES);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

  // Handshakes: a commit entry transfers on a rising edge where
  // cmt_i_valid & cmt_i_ready (ready is a function of state only); the flush
  // request stays high with a stable PC until an edge that sees brchmis_flush_ack.

  state_e             state_q, state_d;
  logic [PC_SIZE-1:0] flush_pc_q, flush_pc_d;
  logic               bpu_valid_q, bpu_valid_d;
  logic [PC_SIZE-1:0] bpu_pc_q, bpu_pc_d;
  logic               bpu_taken_q, bpu_taken_d;
  logic [CNT_W-1:0]   cnt_bjp_q, cnt_bjp_d;
  logic [CNT_W-1:0]   cnt_mis_q, cnt_mis_d;

  logic               hs;
  logic               mis;
  logic               upd;
  logic [PC_SIZE-1:0] imm_t;
  logic [PC_SIZE-1:0] rs1_t;
  logic [PC_SIZE-1:0] jalr_sum;
  logic [PC_SIZE-1:0] target;

  assign cmt_i_ready = (state_q == IDLE);
  assign hs          = cmt_i_valid & cmt_i_ready;
  // JALR carries no target prediction, so it always redirects.
  assign mis         = cmt_i_bjp & (cmt_i_jalr | (cmt_i_bjp_prdt ^ cmt_i_bjp_rslv));
  assign upd         = hs & cmt_i_bjp & ~cmt_i_jalr;

  assign imm_t = cmt_i_imm[PC_SIZE-1:0];
  assign rs1_t = cmt_i_rs1[PC_SIZE-1:0];

  always_comb begin
    jalr_sum = rs1_t + imm_t;
    target   = cmt_i_pc + FALL_INC;
    if (cmt_i_jalr) begin
      target = {jalr_sum[PC_SIZE-1:1], 1'b0};
    end else if (cmt_i_bjp_rslv) begin
      target = cmt_i_pc + imm_t;
    end
  end

  always_comb begin
    state_d    = state_q;
    flush_pc_d = flush_pc_q;
    case (state_q)
      IDLE: begin
        if (hs && mis) begin
          state_d    = FLUSH;
          flush_pc_d = target;
        end
      end
      FLUSH: begin
        if (brchmis_flush_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bpu_valid_d = upd;
    bpu_pc_d    = bpu_pc_q;
    bpu_taken_d = bpu_taken_q;
    if (upd) begin
      bpu_pc_d    = cmt_i_pc;
      bpu_taken_d = cmt_i_bjp_rslv;
    end
  end

  // Counters saturate at all-ones; a clear wins over a same-cycle increment.
  always_comb begin
    cnt_bjp_d = cnt_bjp_q;
    cnt_mis_d = cnt_mis_q;
    if (cnt_clr) begin
      cnt_bjp_d = '0;
      cnt_mis_d = '0;
    end else begin
      if (hs && cmt_i_bjp && (cnt_bjp_q != CNT_MAX)) begin
        cnt_bjp_d = cnt_bjp_q + 1'b1;
      end
      if (hs && mis && (cnt_mis_q != CNT_MAX)) begin
        cnt_mis_d = cnt_mis_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      flush_pc_q  <= '0;
      bpu_valid_q <= 1'b0;
      bpu_pc_q    <= '0;
      bpu_taken_q <= 1'b0;
      cnt_bjp_q   <= '0;
      cnt_mis_q   <= '0;
    end else begin
      state_q     <= state_d;
      flush_pc_q  <= flush_pc_d;
      bpu_valid_q <= bpu_valid_d;
      bpu_pc_q    <= bpu_pc_d;
      bpu_taken_q <= bpu_taken_d;
      cnt_bjp_q   <= cnt_bjp_d;
      cnt_mis_q   <= cnt_mis_d;
    end
  end

  assign brchmis_flush_req = (state_q == FLUSH);
  assign brchmis_flush_pc  = flush_pc_q;
  assign bpu_upd_valid     = bpu_valid_q;
  assign bpu_upd_pc        = bpu_pc_q;
  assign bpu_upd_taken     = bpu_taken_q;
  assign cnt_bjp           = cnt_bjp_q;
  assign cnt_mis           = cnt_mis_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_exu_brchslv_reg.sv
// Bench for exu_brchslv_reg: directed commits push expected flush targets and
// predictor updates into queues that a negedge monitor pops and compares.
module tb_exu_brchslv_reg;
  localparam int PW = 32;
  localparam int XW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmt_i_valid;
  logic          cmt_i_ready;
  logic          cmt_i_bjp;
  logic          cmt_i_jalr;
  logic          cmt_i_bjp_prdt;
  logic          cmt_i_bjp_rslv;
  logic [PW-1:0] cmt_i_pc;
  logic [XW-1:0] cmt_i_imm;
  logic [XW-1:0] cmt_i_rs1;
  logic          brchmis_flush_req;
  logic          brchmis_flush_ack;
  logic [PW-1:0] brchmis_flush_pc;
  logic          bpu_upd_valid;
  logic [PW-1:0] bpu_upd_pc;
  logic          bpu_upd_taken;
  logic          cnt_clr;
  logic [CW-1:0] cnt_bjp;
  logic [CW-1:0] cnt_mis;
  logic          dbg_state_o;

  logic [PW-1:0] exp_flush_q[$];
  logic [PW:0]   exp_bpu_q[$];
  int errors = 0;
  int checks = 0;

  exu_brchslv_reg #(.PC_SIZE(PW), .XLEN(XW), .CNT_W(CW), .INSTR_BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .cmt_i_valid(cmt_i_valid), .cmt_i_ready(cmt_i_ready),
    .cmt_i_bjp(cmt_i_bjp), .cmt_i_jalr(cmt_i_jalr),
    .cmt_i_bjp_prdt(cmt_i_bjp_prdt), .cmt_i_bjp_rslv(cmt_i_bjp_rslv),
    .cmt_i_pc(cmt_i_pc), .cmt_i_imm(cmt_i_imm), .cmt_i_rs1(cmt_i_rs1),
    .brchmis_flush_req(brchmis_flush_req), .brchmis_flush_ack(brchmis_flush_ack),
    .brchmis_flush_pc(brchmis_flush_pc),
    .bpu_upd_valid(bpu_upd_valid), .bpu_upd_pc(bpu_upd_pc), .bpu_upd_taken(bpu_upd_taken),
    .cnt_clr(cnt_clr), .cnt_bjp(cnt_bjp), .cnt_mis(cnt_mis),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: issues one entry; returns 1 time unit after the accepting edge
  task automatic commit(input logic bjp, input logic jalr, input logic prdt, input logic rslv,
                        input logic [PW-1:0] pc, input logic [XW-1:0] imm,
                        input logic [XW-1:0] rs1, input logic [PW-1:0] exp_tgt);
    int n = 0;
    while (cmt_i_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (cmt_i_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL commit_wait: actual ready=%b required ready=1 within 20 cycles", cmt_i_ready);
      return;
    end
    cmt_i_bjp      = bjp;
    cmt_i_jalr     = jalr;
    cmt_i_bjp_prdt = prdt;
    cmt_i_bjp_rslv = rslv;
    cmt_i_pc       = pc;
    cmt_i_imm      = imm;
    cmt_i_rs1      = rs1;
    cmt_i_valid    = 1'b1;
    if (bjp && (jalr || (prdt != rslv))) exp_flush_q.push_back(exp_tgt);
    if (bjp && !jalr) exp_bpu_q.push_back({rslv, pc});
    tick();
    cmt_i_valid = 1'b0;
  endtask

  // monitor / scoreboard
  logic          req_prev = 1'b0;
  logic [PW-1:0] held_pc = '0;
  logic [PW:0]   exp_bpu;
  logic [PW-1:0] exp_pc;

  always @(negedge clk) begin
    if (bpu_upd_valid === 1'b1) begin
      if (exp_bpu_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bpu_unexpected: actual pulse pc=%0h required no pulse", bpu_upd_pc);
      end else begin
        exp_bpu = exp_bpu_q.pop_front();
        check("bpu_upd", 64'({bpu_upd_taken, bpu_upd_pc}), 64'(exp_bpu));
      end
    end
    if (brchmis_flush_req === 1'b1) begin
      if (!req_prev) begin
        if (exp_flush_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL flush_unexpected: actual req pc=%0h required no req", brchmis_flush_pc);
        end else begin
          exp_pc = exp_flush_q.pop_front();
          check("flush_pc", 64'(brchmis_flush_pc), 64'(exp_pc));
        end
        held_pc = brchmis_flush_pc;
      end else begin
        check("flush_pc_stable", 64'(brchmis_flush_pc), 64'(held_pc));
      end
    end
    req_prev = (brchmis_flush_req === 1'b1);
  end

  // stimulus
  initial begin
    rst = 1'b1;
    cmt_i_valid = 1'b0; cmt_i_bjp = 1'b0; cmt_i_jalr = 1'b0;
    cmt_i_bjp_prdt = 1'b0; cmt_i_bjp_rslv = 1'b0;
    cmt_i_pc = '0; cmt_i_imm = '0; cmt_i_rs1 = '0;
    brchmis_flush_ack = 1'b0; cnt_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;

    check("rst_ready", 64'(cmt_i_ready), 64'd1);
    check("rst_req", 64'(brchmis_flush_req), 64'd0);
    check("rst_flush_pc", 64'(brchmis_flush_pc), 64'd0);
    check("rst_bpu", 64'({bpu_upd_valid, bpu_upd_taken, bpu_upd_pc}), 64'd0);
    check("rst_cnt", 64'({cnt_bjp, cnt_mis}), 64'd0);

    // taken mispredict, ack held low for a while
    commit(1, 0, 0, 1, 32'h100, 32'h40, 32'h0, 32'h140);
    check("t1_req", 64'(brchmis_flush_req), 64'd1);
    check("t1_pc", 64'(brchmis_flush_pc), 64'h140);
    check("t1_ready", 64'(cmt_i_ready), 64'd0);
    check("t1_state", 64'(dbg_state_o), 64'd1);
    check("t1_bpu_valid", 64'(bpu_upd_valid), 64'd1);
    check("t1_cnt", 64'({cnt_bjp, cnt_mis}), 64'h11);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_hold_req", 64'(brchmis_flush_req), 64'd1);
      check("t1_hold_ready", 64'(cmt_i_ready), 64'd0);
    end
    brchmis_flush_ack = 1'b1;
    tick();
    brchmis_flush_ack = 1'b0;
    check("t1_ack_req", 64'(brchmis_flush_req), 64'd0);
    check("t1_ack_ready", 64'(cmt_i_ready), 64'd1);

    // not-taken mispredict, ack in the first req cycle
    commit(1, 0, 1, 0, 32'h200, 32'h80, 32'h0, 32'h204);
    brchmis_flush_ack = 1'b1;
    check("t2_req", 64'(brchmis_flush_req), 64'd1);
    check("t2_pc", 64'(brchmis_flush_pc), 64'h204);
    tick();
    brchmis_flush_ack = 1'b0;
    check("t2_req_one_cycle", 64'(brchmis_flush_req), 64'd0);
    check("t2_ready", 64'(cmt_i_ready), 64'd1);
    check("t2_cnt", 64'({cnt_bjp, cnt_mis}), 64'h22);

    // JALR always flushes, bit0 cleared, no predictor update
    commit(1, 1, 1, 1, 32'h300, 32'h10, 32'h1003, 32'h1012);
    check("t3_req", 64'(brchmis_flush_req), 64'd1);
    check("t3_pc", 64'(brchmis_flush_pc), 64'h1012);
    check("t3_no_bpu", 64'(bpu_upd_valid), 64'd0);
    check("t3_cnt", 64'({cnt_bjp, cnt_mis}), 64'h33);
    brchmis_flush_ack = 1'b1;
    tick();
    brchmis_flush_ack = 1'b0;

    // ack while idle has no effect
    brchmis_flush_ack = 1'b1;
    tick();
    brchmis_flush_ack = 1'b0;
    check("idle_ack_req", 64'(brchmis_flush_req), 64'd0);
    check("idle_ack_ready", 64'(cmt_i_ready), 64'd1);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnt", 64'({cnt_bjp, cnt_mis}), 64'h00);

    // back-to-back correctly predicted branches
    for (int i = 0; i < 5; i++) begin
      commit(1, 0, i[0], i[0], 32'h400 + 32'(i * 4), 32'h20, 32'h0, 32'h0);
      check("b2b_bpu_valid", 64'(bpu_upd_valid), 64'd1);
      check("b2b_ready", 64'(cmt_i_ready), 64'd1);
      check("b2b_req", 64'(brchmis_flush_req), 64'd0);
    end
    commit(0, 0, 0, 1, 32'h480, 32'h40, 32'h0, 32'h0);
    check("nonbjp_bpu", 64'(bpu_upd_valid), 64'd0);
    commit(0, 1, 1, 1, 32'h484, 32'h40, 32'h7, 32'h0);
    check("nonbjp_req", 64'(brchmis_flush_req), 64'd0);
    check("b2b_cnt", 64'({cnt_bjp, cnt_mis}), 64'h50);

    // PC wrap-around on target
    commit(1, 0, 0, 1, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0000_0010);
    check("wrap_pc", 64'(brchmis_flush_pc), 64'h10);
    check("wrap_cnt", 64'({cnt_bjp, cnt_mis}), 64'h61);
    brchmis_flush_ack = 1'b1;
    tick();
    brchmis_flush_ack = 1'b0;

    // saturation of the 4-bit branch counter
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      commit(1, 0, 1, 1, 32'h800 + 32'(i * 4), 32'h100, 32'h0, 32'h0);
      if (i == 14) check("sat_cnt15", 64'(cnt_bjp), 64'hF);
    end
    check("sat_cnt16", 64'(cnt_bjp), 64'hF);
    check("sat_mis", 64'(cnt_mis), 64'h0);

    // clear wins over a simultaneous increment
    cnt_clr = 1'b1;
    commit(1, 0, 0, 1, 32'h500, 32'h8, 32'h0, 32'h508);
    cnt_clr = 1'b0;
    check("clr_pri_cnt", 64'({cnt_bjp, cnt_mis}), 64'h00);
    check("clr_pri_req", 64'(brchmis_flush_req), 64'd1);
    brchmis_flush_ack = 1'b1;
    tick();
    brchmis_flush_ack = 1'b0;

    // reset while a flush is pending
    commit(1, 0, 1, 0, 32'h600, 32'h4, 32'h0, 32'h604);
    check("rf_req", 64'(brchmis_flush_req), 64'd1);
    tick();
    check("rf_hold", 64'(brchmis_flush_req), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rf_req_drop", 64'(brchmis_flush_req), 64'd0);
    check("rf_ready", 64'(cmt_i_ready), 64'd1);
    check("rf_state", 64'(dbg_state_o), 64'd0);
    check("rf_flush_pc", 64'(brchmis_flush_pc), 64'd0);
    check("rf_cnt", 64'({cnt_bjp, cnt_mis}), 64'h00);

    tick(); tick();
    check("flush_q_empty", 64'(exp_flush_q.size()), 64'd0);
    check("bpu_q_empty", 64'(exp_bpu_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
